// File: rtl/nios_memory_stream_loader.sv
// Byte-stream to 32-bit word loader for the on-chip program/data memory.
// Bytes are packed little-endian and written with zero-wait-state slave-port writes.
module nios_memory_stream_loader #(
   parameter int ADDR_WIDTH = 11,
   parameter int CNT_WIDTH  = 14
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  byte_count,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [3:0]            mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [31:0]           mem_writedata,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [CNT_WIDTH-1:0]  remain_reg, remain_next;
   logic [1:0]            lane_reg, lane_next;
   logic [31:0]           pack_reg, pack_next;
   logic [3:0]            be_reg, be_next;

   logic [ADDR_WIDTH-1:0] mem_address_reg;
   logic [31:0]           mem_writedata_reg;
   logic [3:0]            mem_byteenable_reg;
   logic                  mem_chipselect_reg;
   logic                  mem_write_reg;
   logic                  busy_reg;
   logic                  done_reg;

   logic                  accept;
   logic                  entering_write;
   logic [3:0]            lane_hit;
   logic [31:0]           pack_fill;
   logic [3:0]            be_fill;

   assign in_ready = (state_reg == FILL);
   assign accept   = (state_reg == FILL) && in_valid;

   // Per-lane merge of the incoming byte into the packing register.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_hit[gi]           = accept && (lane_reg == 2'(gi));
         assign pack_fill[8*gi +: 8]   = lane_hit[gi] ? in_data : pack_reg[8*gi +: 8];
         assign be_fill[gi]            = be_reg[gi] | lane_hit[gi];
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      remain_next = remain_reg;
      lane_next   = lane_reg;
      pack_next   = pack_reg;
      be_next     = be_reg;
      case (state_reg)
         IDLE: begin
            // The done pulse trails the DONE state by a cycle; a start there is ignored too.
            if (start && !done_reg) begin
               addr_next   = base_addr;
               remain_next = byte_count;
               lane_next   = 2'd0;
               pack_next   = 32'd0;
               be_next     = 4'd0;
               state_next  = (byte_count == '0) ? DONE : FILL;
            end
         end
         FILL: begin
            if (accept) begin
               pack_next   = pack_fill;
               be_next     = be_fill;
               remain_next = remain_reg - CNT_WIDTH'(1);
               lane_next   = lane_reg + 2'd1;
               if (lane_reg == 2'd3 || remain_reg == CNT_WIDTH'(1)) begin
                  state_next = WRITE;
               end
            end
         end
         WRITE: begin
            addr_next  = addr_reg + ADDR_WIDTH'(1);
            pack_next  = 32'd0;
            be_next    = 4'd0;
            lane_next  = 2'd0;
            state_next = (remain_reg == '0) ? DONE : FILL;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign entering_write = (state_next == WRITE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         addr_reg   <= '0;
         remain_reg <= '0;
         lane_reg   <= 2'd0;
         pack_reg   <= 32'd0;
         be_reg     <= 4'd0;
      end else begin
         state_reg  <= state_next;
         addr_reg   <= addr_next;
         remain_reg <= remain_next;
         lane_reg   <= lane_next;
         pack_reg   <= pack_next;
         be_reg     <= be_next;
      end
   end

   // Slave-port outputs are loaded on entry to WRITE so they are registered for that one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_address_reg    <= '0;
         mem_writedata_reg  <= 32'd0;
         mem_byteenable_reg <= 4'd0;
         mem_chipselect_reg <= 1'b0;
         mem_write_reg      <= 1'b0;
         busy_reg           <= 1'b0;
         done_reg           <= 1'b0;
      end else begin
         mem_address_reg    <= entering_write ? addr_reg : '0;
         mem_writedata_reg  <= entering_write ? pack_next : 32'd0;
         mem_byteenable_reg <= entering_write ? be_next : 4'd0;
         mem_chipselect_reg <= entering_write;
         mem_write_reg      <= entering_write;
         busy_reg           <= (state_next != IDLE);
         done_reg           <= (state_reg == DONE);
      end
   end

   assign mem_address    = mem_address_reg;
   assign mem_writedata  = mem_writedata_reg;
   assign mem_byteenable = mem_byteenable_reg;
   assign mem_chipselect = mem_chipselect_reg;
   assign mem_write      = mem_write_reg;
   assign busy           = busy_reg;
   assign done           = done_reg;

endmodule

// File: tb/tb_nios_memory_stream_loader.sv
// Self-checking bench for nios_memory_stream_loader: directed scenarios plus
// randomized loads checked against a word-packing model of the byte stream.
module tb_nios_memory_stream_loader;

   typedef struct {
      logic [10:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] base_addr = '0;
   logic [13:0] byte_count = '0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int start_cyc = -1;
   int last_acc = -1;
   bit noise = 0;
   wr_t obs[$];
   wr_t exp[$];
   logic [7:0] bytes[$];

   nios_memory_stream_loader #(.ADDR_WIDTH(11), .CNT_WIDTH(14)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .byte_count(byte_count), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: logs every write and checks the port protocol each cycle.
   always @(negedge clk) begin
      if (mem_write === 1'b1) begin
         obs.push_back('{addr: mem_address, data: mem_writedata, be: mem_byteenable, cyc: cyc});
         $display("write cyc=%0d addr=%h data=%h be=%h", cyc, mem_address, mem_writedata, mem_byteenable);
         checks++;
         if (mem_chipselect !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_strobes cs=%b in_ready=%b required cs=1 in_ready=0", mem_chipselect, in_ready);
         end
      end else begin
         checks++;
         if ({mem_chipselect, mem_address, mem_writedata, mem_byteenable} !== 48'd0) begin
            failures++;
            $display("FAIL idle_outputs cs=%b addr=%h data=%h be=%h required all 0",
                     mem_chipselect, mem_address, mem_writedata, mem_byteenable);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_done busy=%b required 0", busy);
         end
      end
   end

   // Reference: consecutive groups of 4 bytes, little-endian, addresses wrap at 2048.
   function automatic void model(input int base, input int count);
      exp.delete();
      for (int w = 0; w < (count + 3) / 4; w++) begin
         wr_t e;
         e.addr = 11'((base + w) % 2048);
         e.data = 32'd0;
         e.be   = 4'd0;
         e.cyc  = 0;
         for (int k = 0; k < 4; k++) begin
            if (4 * w + k < count) begin
               e.data = e.data | (32'(bytes[4 * w + k]) << (8 * k));
               e.be   = e.be | 4'(1 << k);
            end
         end
         exp.push_back(e);
      end
   endfunction

   // vmode: 0 = always valid, 1 = pattern 1,0,0,1,0,1,1, 2 = random valid.
   task automatic run_load(input logic [10:0] base, input int count, input int vmode);
      int db;
      int idx;
      int budget;
      int pi;
      bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      obs.delete();
      db = done_cnt;
      last_acc = -1;
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; byte_count = count[13:0]; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      idx = 0; pi = 0; budget = count * 30 + 20;
      while (idx < count && budget > 0) begin
         in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[pi % 7] : 1'($urandom_range(0, 1));
         in_data = bytes[idx];
         pi++;
         if (noise) start = busy && ($urandom_range(0, 2) == 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            idx++;
            last_acc = cyc;
         end
         @(posedge clk); #1;
         budget--;
      end
      in_valid = 1'b0;
      if (idx < count) begin
         failures++;
         $display("FAIL feed_timeout accepted=%0d required=%0d", idx, count);
      end
      budget = 40;
      while (done_cnt == db && budget > 0) begin
         if (noise) start = busy && ($urandom_range(0, 2) == 0);
         @(posedge clk); #1;
         budget--;
      end
      start = 1'b0;
      checks++;
      if (done_cnt == db) begin
         failures++;
         $display("FAIL done_timeout no done pulse within 40 cycles");
      end
      $display("load base=%h count=%0d vmode=%0d writes=%0d done_cyc=%0d", base, count, vmode, obs.size(), done_cyc);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, busy, done, mem_write, mem_chipselect} !== 5'd0 ||
          {mem_address, mem_writedata, mem_byteenable} !== 47'd0) begin
         failures++;
         $display("FAIL reset_outputs rdy=%b busy=%b done=%b wr=%b cs=%b addr=%h data=%h be=%h required all 0",
                  in_ready, busy, done, mem_write, mem_chipselect, mem_address, mem_writedata, mem_byteenable);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_word();
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_load(11'h010, 4, 0);
      checks++;
      if (obs.size() != 1) begin
         failures++;
         $display("FAIL full_word_count got=%0d required=1", obs.size());
      end else begin
         checks++;
         if (obs[0].addr !== 11'h010 || obs[0].data !== 32'h44332211 || obs[0].be !== 4'hF) begin
            failures++;
            $display("FAIL full_word_data got=%h/%h/%h required=010/44332211/f", obs[0].addr, obs[0].data, obs[0].be);
         end
         checks++;
         if (obs[0].cyc != last_acc + 1 || done_cyc != obs[0].cyc + 2) begin
            failures++;
            $display("FAIL full_word_timing last_acc=%0d write=%0d done=%0d required write=last_acc+1 done=write+2",
                     last_acc, obs[0].cyc, done_cyc);
         end
      end
   endtask

   task automatic test_partial_tail();
      wr_t want[2];
      want[0] = '{addr: 11'h7FE, data: 32'hA3A2A1A0, be: 4'hF, cyc: 0};
      want[1] = '{addr: 11'h7FF, data: 32'h0000A5A4, be: 4'h3, cyc: 0};
      bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      run_load(11'h7FE, 6, 0);
      checks++;
      if (obs.size() != 2) begin
         failures++;
         $display("FAIL partial_count got=%0d required=2", obs.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i].addr !== want[i].addr || obs[i].data !== want[i].data || obs[i].be !== want[i].be) begin
               failures++;
               $display("FAIL partial_word%0d got=%h/%h/%h required=%h/%h/%h", i, obs[i].addr, obs[i].data,
                        obs[i].be, want[i].addr, want[i].data, want[i].be);
            end
         end
         checks++;
         if (obs[1].cyc != last_acc + 1 || done_cyc != obs[1].cyc + 2) begin
            failures++;
            $display("FAIL partial_timing last_acc=%0d write=%0d done=%0d", last_acc, obs[1].cyc, done_cyc);
         end
      end
   endtask

   task automatic test_wrap_zero();
      wr_t want[2];
      want[0] = '{addr: 11'h7FF, data: 32'h04030201, be: 4'hF, cyc: 0};
      want[1] = '{addr: 11'h000, data: 32'h08070605, be: 4'hF, cyc: 0};
      bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_load(11'h7FF, 8, 0);
      checks++;
      if (obs.size() != 2) begin
         failures++;
         $display("FAIL wrap_count got=%0d required=2", obs.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i].addr !== want[i].addr || obs[i].data !== want[i].data || obs[i].be !== want[i].be) begin
               failures++;
               $display("FAIL wrap_word%0d got=%h/%h/%h required=%h/%h/%h", i, obs[i].addr, obs[i].data,
                        obs[i].be, want[i].addr, want[i].data, want[i].be);
            end
         end
      end
      bytes.delete();
      run_load(11'h123, 0, 0);
      checks++;
      if (obs.size() != 0 || done_cyc != start_cyc + 2) begin
         failures++;
         $display("FAIL zero_length writes=%0d done_cyc=%0d required writes=0 done_cyc=%0d",
                  obs.size(), done_cyc, start_cyc + 2);
      end
   endtask

   task automatic test_stall_and_start();
      bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      noise = 1;
      run_load(11'h123, 4, 1);
      noise = 0;
      checks++;
      if (obs.size() != 1) begin
         failures++;
         $display("FAIL stall_count got=%0d required=1", obs.size());
      end else begin
         checks++;
         if (obs[0].addr !== 11'h123 || obs[0].data !== 32'hEFBEADDE || obs[0].be !== 4'hF) begin
            failures++;
            $display("FAIL stall_data got=%h/%h/%h required=123/efbeadde/f", obs[0].addr, obs[0].data, obs[0].be);
         end
         checks++;
         if (obs[0].cyc != last_acc + 1) begin
            failures++;
            $display("FAIL stall_latency write=%0d required=%0d", obs[0].cyc, last_acc + 1);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL stall_idle busy=%b required 0", busy);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         int base = $urandom_range(0, 2047);
         int count = $urandom_range(0, 13);
         int vmode = $urandom_range(0, 2);
         bytes.delete();
         for (int i = 0; i < count; i++) bytes.push_back(8'($urandom));
         noise = ($urandom_range(0, 1) == 1);
         run_load(11'(base), count, vmode);
         noise = 0;
         model(base, count);
         checks++;
         if (obs.size() != exp.size()) begin
            failures++;
            $display("FAIL random%0d_count got=%0d required=%0d", t, obs.size(), exp.size());
         end else begin
            foreach (exp[i]) begin
               checks++;
               if (obs[i].addr !== exp[i].addr || obs[i].data !== exp[i].data || obs[i].be !== exp[i].be) begin
                  failures++;
                  $display("FAIL random%0d_word%0d got=%h/%h/%h required=%h/%h/%h", t, i, obs[i].addr,
                           obs[i].data, obs[i].be, exp[i].addr, exp[i].data, exp[i].be);
               end
            end
            checks++;
            if (count > 0 && (obs[$].cyc != last_acc + 1 || done_cyc != obs[$].cyc + 2)) begin
               failures++;
               $display("FAIL random%0d_timing last_acc=%0d write=%0d done=%0d", t, last_acc, obs[$].cyc, done_cyc);
            end else if (count == 0 && done_cyc != start_cyc + 2) begin
               failures++;
               $display("FAIL random%0d_zero done=%0d required=%0d", t, done_cyc, start_cyc + 2);
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      obs.delete();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 11'h055; byte_count = 14'd4;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
      @(posedge clk); #1;
      in_data = 8'h22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, done, mem_write, mem_chipselect} !== 5'd0 ||
          {mem_address, mem_writedata, mem_byteenable} !== 47'd0) begin
         failures++;
         $display("FAIL async_reset rdy=%b busy=%b done=%b wr=%b cs=%b addr=%h data=%h be=%h required all 0",
                  in_ready, busy, done, mem_write, mem_chipselect, mem_address, mem_writedata, mem_byteenable);
      end
      @(posedge clk); #3;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs.size() != 0) begin
         failures++;
         $display("FAIL reset_no_write writes=%0d required=0", obs.size());
      end
      bytes = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
      run_load(11'h100, 4, 0);
      checks++;
      if (obs.size() != 1) begin
         failures++;
         $display("FAIL reload_count got=%0d required=1", obs.size());
      end else begin
         checks++;
         if (obs[0].addr !== 11'h100 || obs[0].data !== 32'h8D7C6B5A || obs[0].be !== 4'hF) begin
            failures++;
            $display("FAIL reload_data got=%h/%h/%h required=100/8d7c6b5a/f", obs[0].addr, obs[0].data, obs[0].be);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial_tail();
      test_wrap_zero();
      test_stall_and_start();
      test_random();
      test_reset_mid_load();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
